non_restoring_divider_seq: RTL
==============================

Name: non_restoring_divider_seq

Overview:
- Parametrised, self-contained sequential non-restoring divider. FSM control path and A/Q/M datapath live in one block.
- Successor to the fixed-width divider control path. Adds a start/busy/done handshake, a signed/unsigned mode, divide-by-zero detection and registered results.
- Sits as an arithmetic co-unit beside the datapath: an operand source issues one division at a time and collects the results on done.

Parameters:
- WIDTH, 8, operand/quotient/remainder width in bits (>=2).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when idle or done.
- signed_op  input  1  1 = two's-complement operands; sampled with start.
- dividend  input  WIDTH  sampled with start.
- divisor  input  WIDTH  sampled with start.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; results valid from this cycle.
- quotient  output  WIDTH  registered result.
- remainder  output  WIDTH  registered result.
- div_by_zero  output  1  registered flag for the last operation.

Behaviour:
- Reset: the clock is clk, the reset is rst; reset is synchronous and active-high. On any edge with rst=1: state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; A, Q, M and the counter all cleared. Reset mid-operation aborts the division with no done pulse.
- States:
  - IDLE: start=1 -> LOAD actions, then ITER.
  - ITER: WIDTH cycles, one iteration per cycle.
  - CORRECT: one cycle.
  - DONE: one cycle.
  - Unused encodings -> IDLE.
- LOAD (on the edge sampling start):
  - Compute magnitudes |dividend| and |divisor|. Negate only if signed_op=1 and the MSB is set.
  - Q=|dividend|, M=|divisor| zero-extended to WIDTH+1 bits, A=0 (WIDTH+1 bits), counter=WIDTH.
  - Latch both sign bits and signed_op.
  - If divisor==0: go straight to DONE with quotient=all ones, remainder=dividend (raw), div_by_zero=1.
- ITER (per edge):
  - {A,Q} shifted left by 1.
  - If the old A is non-negative, A=A-M; otherwise A=A+M.
  - Q[0] = NOT new A[WIDTH].
  - counter decrements; when it reaches 0, go to CORRECT.
- CORRECT:
  - If A is negative, A=A+M.
  - Signed sign fix: quotient is negated if the dividend and divisor signs differ. Remainder is negated if the dividend was negative.
  - Register quotient, remainder, div_by_zero=0. Go to DONE.
- Signed overflow (-2^(WIDTH-1) / -1): the quotient wraps to -2^(WIDTH-1) with remainder 0. This is not flagged.
- DONE:
  - done=1 for exactly this cycle.
  - start=1 here -> new LOAD, back-to-back, with no IDLE cycle. Otherwise -> IDLE.
- busy=1 in ITER and CORRECT, and in the LOAD transition cycle. busy=0 in IDLE and DONE.
- start while busy is ignored and does not corrupt the operation in flight.
- Latency: with start sampled at edge k, done is high in the cycle after edge k+WIDTH+1. Divide-by-zero: done is high in the cycle after edge k.
- Outputs hold their last values until the next completed operation or reset. Operand inputs may change freely after the start edge.
- Internal arithmetic is WIDTH+1 bits. Nothing overflows at the A/M boundary for any unsigned WIDTH-bit operands.

Test Plan:
- WIDTH=8, unsigned, 100/7 -> quotient=14, remainder=2, div_by_zero=0; done exactly 9 edges after the start edge; busy high for 9 cycles.
- Signed: -100/7 -> quotient=0xF2 (-14), remainder=0xFE (-2); 100/-7 -> 0xF2, 0x02; -128/-1 -> 0x80, 0x00.
- Divide by zero: 55/0 unsigned -> quotient=0xFF, remainder=55, div_by_zero=1; done one cycle after start. A following 9/3 -> quotient 3, remainder 0, div_by_zero cleared.
- Boundaries: 255/1 -> 255 r 0; 3/200 -> 0 r 3; 0/5 -> 0 r 0; 255/255 -> 1 r 0.
- Handshake:
  - start pulsed mid-ITER with other operands -> ignored; the original result is produced.
  - start held in the DONE cycle -> the next division completes 9 edges later with no idle gap.
- Reset: rst asserted at ITER cycle 4 -> next cycle busy=0, all outputs 0, no done pulse. A fresh 100/7 then completes correctly.
- Randomised sweep (WIDTH=8 and WIDTH=16, both modes) against the reference model q=a/b, r=a%b, with truncation toward zero for signed.

Source files
------------

// File: rtl/non_restoring_divider_seq.sv
// Sequential non-restoring divider with start/busy/done handshake, signed/unsigned mode
// and divide-by-zero detection; one quotient bit per cycle on a WIDTH+1 bit A/M datapath.
module non_restoring_divider_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ITER    = 2'd1,
        S_CORRECT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH:0]   a_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH:0]   m_r;
    logic [CNT_W-1:0] cnt_r;
    logic             dvd_neg_r;
    logic             dvs_neg_r;
    logic             signed_r;

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   a_sh;
    logic [WIDTH:0]   a_next;
    logic [WIDTH:0]   a_fix;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;

    // Operand magnitudes, one iteration step and the final sign/remainder fix-up
    always_comb begin
        dvd_mag = (signed_op && dividend[WIDTH-1]) ? WIDTH'((~dividend) + WIDTH'(1)) : dividend;
        dvs_mag = (signed_op && divisor[WIDTH-1])  ? WIDTH'((~divisor) + WIDTH'(1))  : divisor;
        a_sh    = {a_r[WIDTH-1:0], q_r[WIDTH-1]};
        a_next  = a_r[WIDTH] ? (a_sh + m_r) : (a_sh - m_r);
        a_fix   = a_r[WIDTH] ? (a_r + m_r) : a_r;
        q_fin   = (signed_r && (dvd_neg_r ^ dvs_neg_r)) ? WIDTH'((~q_r) + WIDTH'(1)) : q_r;
        r_fin   = (signed_r && dvd_neg_r) ? WIDTH'((~a_fix[WIDTH-1:0]) + WIDTH'(1))
                                          : a_fix[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            a_r         <= '0;
            q_r         <= '0;
            m_r         <= '0;
            cnt_r       <= '0;
            dvd_neg_r   <= 1'b0;
            dvs_neg_r   <= 1'b0;
            signed_r    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                // DONE accepts a new start directly so back-to-back ops need no idle cycle
                S_IDLE, S_DONE: begin
                    state <= S_IDLE;
                    if (start) begin
                        a_r       <= '0;
                        q_r       <= dvd_mag;
                        m_r       <= {1'b0, dvs_mag};
                        cnt_r     <= CNT_W'(WIDTH);
                        dvd_neg_r <= dividend[WIDTH-1];
                        dvs_neg_r <= divisor[WIDTH-1];
                        signed_r  <= signed_op;
                        if (divisor == '0) begin
                            state       <= S_DONE;
                            done        <= 1'b1;
                            busy        <= 1'b0;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= S_ITER;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_ITER: begin
                    a_r   <= a_next;
                    q_r   <= {q_r[WIDTH-2:0], ~a_next[WIDTH]};
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state <= S_CORRECT;
                    end
                end
                S_CORRECT: begin
                    a_r         <= a_fix;
                    quotient    <= q_fin;
                    remainder   <= r_fin;
                    div_by_zero <= 1'b0;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
